// File: rtl/video_vga_double_n.sv
// Parametrised scandoubler: captures one TV-rate line into a ping-pong buffer and
// plays the previous line out twice at full clock rate, optionally dimming pass 1.
module video_vga_double_n #(
  parameter int  COMP_W   = 2,
  parameter int  NCOMP    = 3,
  parameter int  LINE_LEN = 448,
  parameter int  AW       = 9,
  localparam int PW       = COMP_W * NCOMP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync_start,
  input  logic          scanin_start,
  input  logic          scanout_start,
  input  logic          pix_stb,
  input  logic [PW-1:0] pix_in,
  input  logic          dim_en,
  output logic [PW-1:0] pix_out,
  output logic          pix_out_vld,
  output logic          pass,
  output logic          wr_short
);

  localparam logic [AW-1:0] LAST = AW'(LINE_LEN - 1);

  logic [PW-1:0] mem [2][LINE_LEN];

  logic          wr_bank;
  logic          wr_act;
  logic [AW-1:0] wr_ptr;
  logic          rd_act;
  logic [AW-1:0] rd_ptr;
  logic          rd_bank;
  logic          wr_en;
  logic [PW-1:0] rd_word;
  logic [PW-1:0] shade;

  // Halve every colour component independently (MSB zero-filled).
  function automatic logic [PW-1:0] dim(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = '0;
    for (int k = 0; k < NCOMP; k++) begin
      r[k*COMP_W +: COMP_W] = p[k*COMP_W +: COMP_W] >> 1;
    end
    return r;
  endfunction

  assign rd_bank = ~wr_bank;
  // A strobe coinciding with scanin_start belongs to the previous capture and is dropped.
  assign wr_en   = rst_n & pix_stb & wr_act & ~scanin_start;
  assign rd_word = mem[rd_bank][rd_ptr];
  assign shade   = (pass && dim_en) ? dim(rd_word) : rd_word;

  // NOTE: the line buffer has no reset; its contents are only observed after being written,
  // and leaving it out of reset lets it map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_bank][wr_ptr] <= pix_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_bank  <= 1'b0;
      wr_ptr   <= '0;
      wr_act   <= 1'b0;
      wr_short <= 1'b0;
    end else begin
      wr_short <= scanin_start & wr_act;
      if (hsync_start) begin
        wr_bank <= ~wr_bank;
      end
      if (scanin_start) begin
        wr_ptr <= '0;
        wr_act <= 1'b1;
      end else if (pix_stb && wr_act) begin
        if (wr_ptr == LAST) begin
          wr_act <= 1'b0;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
    end
  end

  // hsync_start outranks scanout_start so a coincident pair always begins pass 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      rd_act <= 1'b0;
      pass   <= 1'b0;
    end else if (hsync_start) begin
      rd_ptr <= '0;
      rd_act <= 1'b1;
      pass   <= 1'b0;
    end else if (scanout_start) begin
      rd_ptr <= '0;
      rd_act <= 1'b1;
      pass   <= 1'b1;
    end else if (rd_act) begin
      if (rd_ptr == LAST) begin
        rd_act <= 1'b0;
      end else begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // Registered read port: data and its valid flag leave together one clock after the address.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_out     <= '0;
      pix_out_vld <= 1'b0;
    end else begin
      pix_out_vld <= rd_act;
      pix_out     <= rd_act ? shade : '0;
    end
  end

endmodule
